// File: rtl/fsmc_bridge.sv
// FSMC async SRAM-style slave to SDRAM controller request-port bridge.
// One word request per FSMC access; the host is stalled through fsmc_nwait.
module fsmc_bridge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SDR_AW      = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       fsmc_a,
    inout  wire  [15:0]       fsmc_d,
    input  logic              fsmc_ne1,
    input  logic              fsmc_nwe,
    input  logic              fsmc_noe,
    input  logic              fsmc_nbl1,
    input  logic              fsmc_nbl0,
    output logic              fsmc_nwait,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [SDR_AW-1:0] req_addr,
    output logic [15:0]       req_wdata,
    output logic [1:0]        req_be,
    input  logic              rsp_valid,
    input  logic [15:0]       rsp_data,
    output logic              busy
);

    localparam int unsigned DW = 16;
    localparam int unsigned SW = SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_REL     = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [SW-1:0]     r_sync_ne1;
    logic [SW-1:0]     r_sync_nwe;
    logic [SW-1:0]     r_sync_noe;
    logic              w_s_ne1;
    logic              w_s_nwe;
    logic              w_s_noe;

    logic [DW-1:0]     r_rd_data;
    logic              r_rd_hold;
    logic              w_d_oe;
    logic              w_handshake;

    logic              w_req_valid_nxt;
    logic              w_req_we_nxt;
    logic [SDR_AW-1:0] w_req_addr_nxt;
    logic [DW-1:0]     w_req_wdata_nxt;
    logic [1:0]        w_req_be_nxt;
    logic              w_nwait_nxt;
    logic              w_busy_nxt;
    logic [DW-1:0]     w_rd_data_nxt;
    logic              w_rd_hold_nxt;

    // Strobe synchronisers, reset to the deasserted level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync_ne1 <= '1;
            r_sync_nwe <= '1;
            r_sync_noe <= '1;
        end else begin
            r_sync_ne1 <= {r_sync_ne1[SW-2:0], fsmc_ne1};
            r_sync_nwe <= {r_sync_nwe[SW-2:0], fsmc_nwe};
            r_sync_noe <= {r_sync_noe[SW-2:0], fsmc_noe};
        end
    end

    assign w_s_ne1     = r_sync_ne1[SW-1];
    assign w_s_nwe     = r_sync_nwe[SW-1];
    assign w_s_noe     = r_sync_noe[SW-1];
    assign w_handshake = r_req_valid_q();

    function automatic logic r_req_valid_q();
        return req_valid & req_ready;
    endfunction

    // Read data goes out on the raw pins so the host sees it without sync delay
    assign w_d_oe = r_rd_hold & ~fsmc_ne1 & ~fsmc_noe & fsmc_nwe;
    assign fsmc_d = w_d_oe ? r_rd_data : {DW{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_s_ne1 && !w_s_nwe) begin
                    w_state_nxt = ST_WR_REQ;
                end else if (!w_s_ne1 && !w_s_noe) begin
                    w_state_nxt = ST_RD_REQ;
                end
            end
            ST_WR_REQ:  if (w_handshake) w_state_nxt = ST_REL;
            ST_RD_REQ:  if (w_handshake) w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (rsp_valid)   w_state_nxt = ST_REL;
            ST_REL:     if (w_s_ne1)     w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req_valid_nxt = req_valid;
        w_req_we_nxt    = req_we;
        w_req_addr_nxt  = req_addr;
        w_req_wdata_nxt = req_wdata;
        w_req_be_nxt    = req_be;
        w_nwait_nxt     = fsmc_nwait;
        w_rd_data_nxt   = r_rd_data;
        w_rd_hold_nxt   = r_rd_hold;
        case (r_state)
            ST_IDLE: begin
                if (!w_s_ne1 && !w_s_nwe) begin
                    w_req_valid_nxt = 1'b1;
                    w_req_we_nxt    = 1'b1;
                    w_req_addr_nxt  = SDR_AW'(fsmc_a);
                    w_req_wdata_nxt = fsmc_d;
                    w_req_be_nxt    = {~fsmc_nbl1, ~fsmc_nbl0};
                    w_nwait_nxt     = 1'b0;
                end else if (!w_s_ne1 && !w_s_noe) begin
                    w_req_valid_nxt = 1'b1;
                    w_req_we_nxt    = 1'b0;
                    w_req_addr_nxt  = SDR_AW'(fsmc_a);
                    w_req_be_nxt    = 2'b11;
                    w_nwait_nxt     = 1'b0;
                end
            end
            ST_WR_REQ: begin
                if (w_handshake) begin
                    w_req_valid_nxt = 1'b0;
                    w_nwait_nxt     = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (w_handshake) begin
                    w_req_valid_nxt = 1'b0;
                end
            end
            ST_RD_WAIT: begin
                if (rsp_valid) begin
                    w_rd_data_nxt = rsp_data;
                    w_rd_hold_nxt = 1'b1;
                    w_nwait_nxt   = 1'b1;
                end
            end
            ST_REL: begin
                if (w_s_ne1) begin
                    w_rd_hold_nxt = 1'b0;
                end
            end
            default: begin
                w_req_valid_nxt = 1'b0;
                w_nwait_nxt     = 1'b1;
                w_rd_hold_nxt   = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_valid  <= 1'b0;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_be     <= '0;
            fsmc_nwait <= 1'b1;
            busy       <= 1'b0;
            r_rd_data  <= '0;
            r_rd_hold  <= 1'b0;
        end else begin
            req_valid  <= w_req_valid_nxt;
            req_we     <= w_req_we_nxt;
            req_addr   <= w_req_addr_nxt;
            req_wdata  <= w_req_wdata_nxt;
            req_be     <= w_req_be_nxt;
            fsmc_nwait <= w_nwait_nxt;
            busy       <= w_busy_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_hold  <= w_rd_hold_nxt;
        end
    end

endmodule

// File: tb/tb_fsmc_bridge.sv
// Bench for fsmc_bridge: directed FSMC accesses, request scoreboard, pin-level checks.
module tb_fsmc_bridge;

    localparam int unsigned AW = 22;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic [1:0]    be;
    } req_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   fsmc_a;
    wire  [15:0]   fsmc_d;
    logic          fsmc_ne1, fsmc_nwe, fsmc_noe, fsmc_nbl1, fsmc_nbl0;
    logic          fsmc_nwait;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [15:0]   req_wdata;
    logic [1:0]    req_be;
    logic          rsp_valid;
    logic [15:0]   rsp_data;
    logic          busy;

    logic [15:0]   tb_d;
    logic          tb_d_oe;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_req    = 0;
    req_t          exp_q[$];

    assign fsmc_d = tb_d_oe ? tb_d : 16'bz;

    always #5 clk = ~clk;

    fsmc_bridge #(.SYNC_STAGES(2), .SDR_AW(AW)) dut (
        .clk(clk), .rst(rst), .fsmc_a(fsmc_a), .fsmc_d(fsmc_d),
        .fsmc_ne1(fsmc_ne1), .fsmc_nwe(fsmc_nwe), .fsmc_noe(fsmc_noe),
        .fsmc_nbl1(fsmc_nbl1), .fsmc_nbl0(fsmc_nbl0), .fsmc_nwait(fsmc_nwait),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted request is compared against the next expected one
    always @(negedge clk) begin
        if (rst && req_valid && req_ready) begin
            n_req++;
            if (exp_q.size() == 0) begin
                check("unexpected_req", 32'(req_addr), 32'hFFFF_FFFF);
            end else begin
                req_t e;
                e = exp_q.pop_front();
                check("req_we", 32'(req_we), 32'(e.we));
                check("req_addr", 32'(req_addr), 32'(e.addr));
                check("req_be", 32'(req_be), 32'(e.be));
                if (e.we) check("req_wdata", 32'(req_wdata), 32'(e.wdata));
            end
        end
    end

    task automatic wait_req(input int target, input int max, input string name);
        for (int i = 0; i < max; i++) begin
            @(negedge clk); #1;
            if (n_req >= target) break;
        end
        check(name, 32'(n_req >= target), 32'd1);
    endtask

    task automatic wait_nwait_high(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (fsmc_nwait) break;
        end
        check(name, 32'(fsmc_nwait), 32'd1);
    endtask

    task automatic wait_idle(input int max, input string name);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic release_bus();
        @(posedge clk); #1;
        fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1; fsmc_noe = 1'b1;
        fsmc_nbl1 = 1'b1; fsmc_nbl0 = 1'b1; tb_d_oe = 1'b0;
    endtask

    task automatic start_access(input logic [15:0] a, input logic [15:0] d,
                                input logic nwe, input logic noe,
                                input logic nbl1, input logic nbl0);
        @(posedge clk); #1;
        fsmc_a = a; tb_d = d; tb_d_oe = ~nwe;
        fsmc_nbl1 = nbl1; fsmc_nbl0 = nbl0;
        fsmc_ne1 = 1'b0; fsmc_nwe = nwe; fsmc_noe = noe;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; fsmc_a = '0; tb_d = '0; tb_d_oe = 1'b0;
        fsmc_ne1 = 1'b1; fsmc_nwe = 1'b1; fsmc_noe = 1'b1;
        fsmc_nbl1 = 1'b1; fsmc_nbl0 = 1'b1;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;

        repeat (3) @(negedge clk);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_nwait", 32'(fsmc_nwait), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_we", 32'(req_we), 32'd0);
        check("rst_payload", {req_be, 14'(req_addr), req_wdata}, 32'd0);
        check("rst_d_oe", 32'(dut.w_d_oe), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // Full-word write, long strobe, ready already high
        exp_q.push_back('{we: 1'b1, addr: 22'h00AAAA, wdata: 16'hBBBB, be: 2'b11});
        req_ready = 1'b1;
        start_access(16'hAAAA, 16'hBBBB, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("wr_lat_early", 32'(req_valid), 32'd0);
        @(negedge clk);
        check("wr_lat_valid", 32'(req_valid), 32'd1);
        check("wr_nwait_low", 32'(fsmc_nwait), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("wr_valid_drop", 32'(req_valid), 32'd0);
        check("wr_nwait_rel", 32'(fsmc_nwait), 32'd1);
        repeat (4990) @(posedge clk);
        @(negedge clk);
        check("wr_no_retrig_busy", 32'(busy), 32'd1);
        check("wr_single_req", 32'(n_req), 32'd1);
        release_bus();
        wait_idle(8, "wr_idle");

        // Lower-byte write with controller back-pressure
        exp_q.push_back('{we: 1'b1, addr: 22'h00CCCC, wdata: 16'hDDDD, be: 2'b01});
        req_ready = 1'b0;
        start_access(16'hCCCC, 16'hDDDD, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(req_valid), 32'd1);
            check("bp_addr", 32'(req_addr), 32'h0000_CCCC);
            check("bp_be", 32'(req_be), 32'd1);
            check("bp_wdata", 32'(req_wdata), 32'h0000_DDDD);
            check("bp_nwait", 32'(fsmc_nwait), 32'd0);
        end
        @(posedge clk); #1 req_ready = 1'b1;
        wait_nwait_high(5, "bp_nwait_rel");
        check("bp_valid_drop", 32'(req_valid), 32'd0);
        release_bus();
        wait_idle(8, "bp_idle");

        // Read, response 8 clk after acceptance, data driven until ne1 rises
        exp_q.push_back('{we: 1'b0, addr: 22'h001000, wdata: 16'h0000, be: 2'b11});
        start_access(16'h1000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_req(3, 10, "rd_req_seen");
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("rd_nwait_stall", 32'(fsmc_nwait), 32'd0);
        check("rd_d_hiz_wait", 32'(dut.w_d_oe), 32'd0);
        @(posedge clk); #1 rsp_valid = 1'b1; rsp_data = 16'h1234;
        @(posedge clk); #1 rsp_valid = 1'b0; rsp_data = 16'h0000;
        @(negedge clk);
        check("rd_nwait_rel", 32'(fsmc_nwait), 32'd1);
        check("rd_d_oe", 32'(dut.w_d_oe), 32'd1);
        check("rd_d_value", 32'(fsmc_d), 32'h0000_1234);
        @(posedge clk); #1 fsmc_ne1 = 1'b1;
        #1 check("rd_d_hiz_after", 32'(dut.w_d_oe), 32'd0);
        release_bus();
        wait_idle(8, "rd_idle");

        // Read with early host release before the response
        exp_q.push_back('{we: 1'b0, addr: 22'h002002, wdata: 16'h0000, be: 2'b11});
        start_access(16'h2002, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_req(4, 10, "er_req_seen");
        release_bus();
        repeat (3) @(posedge clk);
        #1 rsp_valid = 1'b1; rsp_data = 16'h5678;
        @(posedge clk); #1 rsp_valid = 1'b0; rsp_data = 16'h0000;
        @(negedge clk);
        check("er_nwait", 32'(fsmc_nwait), 32'd1);
        check("er_d_hiz", 32'(dut.w_d_oe), 32'd0);
        check("er_busy_rel", 32'(busy), 32'd1);
        @(negedge clk);
        check("er_idle", 32'(busy), 32'd0);

        // Both strobes low: write wins, held strobes do not re-trigger
        exp_q.push_back('{we: 1'b1, addr: 22'h003003, wdata: 16'h0F0F, be: 2'b11});
        start_access(16'h3003, 16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_req(5, 10, "both_req_seen");
        wait_nwait_high(5, "both_nwait_rel");
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("both_single_req", 32'(n_req), 32'd5);
        release_bus();
        wait_idle(8, "both_idle");

        // Reset while waiting for read data
        exp_q.push_back('{we: 1'b0, addr: 22'h004004, wdata: 16'h0000, be: 2'b11});
        start_access(16'h4004, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_req(6, 10, "rst_rd_req_seen");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pre_nwait", 32'(fsmc_nwait), 32'd0);
        check("rst_pre_busy", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_valid", 32'(req_valid), 32'd0);
        check("rst_mid_nwait", 32'(fsmc_nwait), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_d_hiz", 32'(dut.w_d_oe), 32'd0);
        release_bus();
        @(posedge clk); #1 rst = 1'b1;
        repeat (4) @(posedge clk);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("req_total", 32'(n_req), 32'd6);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
